// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one single-port data memory between two requesters.
// Port 0 is the core load/store unit and port 1 is the debug/program loader.
// Arbitration is round-robin and decided in a single cycle. Read data is
// registered and returned one cycle after the grant.
//
// Optional feature macro: DM_CLEAR_EN. When it is defined, a post-reset
// sweep zero-fills every memory word before any requester is served.
//
// Ports:
//   clk, rst              clock (rising edge); asynchronous active-high reset
//   mX_req/we/addr/wd     port X request (level), write enable, word address, write data
//   mX_gnt                port X granted this cycle (combinational)
//   mX_rdata/mX_rvalid    port X registered read data and its one-cycle valid pulse
//   dm_addr/dm_we/dm_wd   memory address {zeros, addr}, write enable, write data (combinational)
//   dm_rd                 memory read data, combinational from dm_addr
//   busy                  clear sweep in progress
module dm_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wd,
    output logic              m0_gnt,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wd,
    output logic              m1_gnt,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rvalid,
    output logic [15:0]       dm_addr,
    output logic              dm_we,
    output logic [DATA_W-1:0] dm_wd,
    input  logic [DATA_W-1:0] dm_rd,
    output logic              busy
);

    localparam int unsigned DM_ADDR_W = 16;

`ifdef DM_CLEAR_EN
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_SERVE = 1'b1} state_t;
    localparam state_t ST_RESET = ST_CLEAR;
`else
    typedef enum logic [0:0] {ST_SERVE = 1'b1} state_t;
    localparam state_t ST_RESET = ST_SERVE;
`endif

    state_t              state, state_nxt;
    logic                last_gnt, last_gnt_nxt;   // 1: port 1 was granted most recently
    logic                gnt0, gnt1;
    logic [ADDR_W-1:0]   sel_addr;
    logic                sel_we;
    logic [DATA_W-1:0]   sel_wd;
`ifdef DM_CLEAR_EN
    logic [ADDR_W-1:0]   clr_idx, clr_idx_nxt;
`endif

    // State, arbitration history and sweep index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RESET;
            last_gnt <= 1'b1;
`ifdef DM_CLEAR_EN
            clr_idx  <= '0;
`endif
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
`ifdef DM_CLEAR_EN
            clr_idx  <= clr_idx_nxt;
`endif
        end
    end

    // Next state, grant decision and memory-side mux
    always_comb begin
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        sel_addr     = '0;
        sel_we       = 1'b0;
        sel_wd       = '0;
`ifdef DM_CLEAR_EN
        clr_idx_nxt  = clr_idx;
`endif
        case (state)
`ifdef DM_CLEAR_EN
            ST_CLEAR: begin
                sel_we      = 1'b1;
                sel_addr    = clr_idx;
                clr_idx_nxt = clr_idx + ADDR_W'(1);
                if (clr_idx == ADDR_W'(DEPTH - 1)) begin
                    state_nxt = ST_SERVE;
                end
            end
`endif
            ST_SERVE: begin
                // On a tie the port that did not win last time is served
                if (m0_req && m1_req) begin
                    gnt0 = last_gnt;
                    gnt1 = ~last_gnt;
                end else begin
                    gnt0 = m0_req;
                    gnt1 = m1_req;
                end
                if (gnt0) begin
                    sel_addr     = m0_addr;
                    sel_we       = m0_we;
                    sel_wd       = m0_wd;
                    last_gnt_nxt = 1'b0;
                end else if (gnt1) begin
                    sel_addr     = m1_addr;
                    sel_we       = m1_we;
                    sel_wd       = m1_wd;
                    last_gnt_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_SERVE;
            end
        endcase
        // Nothing reaches the memory or the requesters while reset is held
        if (rst) begin
            gnt0     = 1'b0;
            gnt1     = 1'b0;
            sel_addr = '0;
            sel_we   = 1'b0;
            sel_wd   = '0;
        end
    end

    // Read-data capture: one-cycle valid pulse, data held until the next read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
        end else begin
            m0_rvalid <= gnt0 & ~m0_we;
            m1_rvalid <= gnt1 & ~m1_we;
            if (gnt0 && !m0_we) begin
                m0_rdata <= dm_rd;
            end
            if (gnt1 && !m1_we) begin
                m1_rdata <= dm_rd;
            end
        end
    end

    assign m0_gnt  = gnt0;
    assign m1_gnt  = gnt1;
    assign dm_addr = DM_ADDR_W'(sel_addr);
    assign dm_we   = sel_we;
    assign dm_wd   = sel_wd;

`ifdef DM_CLEAR_EN
    assign busy = (state == ST_CLEAR);
`else
    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed bench for dm_arbiter with a behavioural data memory.
// Works with and without DM_CLEAR_EN defined.
module tb_dm_arbiter;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 32;
`ifdef DM_CLEAR_EN
    localparam bit EXP_BUSY_RST = 1'b1;
`else
    localparam bit EXP_BUSY_RST = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              m0_req, m0_we, m1_req, m1_we;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_wd, m1_wd;
    logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic [15:0]       dm_addr;
    logic              dm_we;
    logic [DATA_W-1:0] dm_wd, dm_rd;
    logic              busy;
    logic              preload;
    logic [DATA_W-1:0] mem [DEPTH];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .dm_addr(dm_addr), .dm_we(dm_we), .dm_wd(dm_wd), .dm_rd(dm_rd),
        .busy(busy)
    );

    // Data memory: non-zero preload so a zero-fill is observable
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hA5A5_0000 | DATA_W'(i);
        end else if (dm_we) begin
            mem[dm_addr[ADDR_W-1:0]] <= dm_wd;
        end
    end
    assign dm_rd = mem[dm_addr[ADDR_W-1:0]];

    task automatic idle_inputs();
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wd = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wd = '0;
    endtask

    // Pulse reset for one cycle, then wait out any sweep (bounded)
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`ifdef DM_CLEAR_EN
        begin
            int n = 0;
            while (busy && n < 40) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n !== 32) begin
                failures++;
                $display("FAIL sweep_len: got %0d cycles, expected 32", n);
            end
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; preload = 1'b1;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 5'd7; m0_wd = 32'h1111_1111;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 5'd9; m1_wd = 32'h2222_2222;
        @(posedge clk);
        preload = 1'b0;
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b00) begin
            failures++; $display("FAIL rst_gnt: got %b expected 00", {m0_gnt, m1_gnt});
        end
        checks++;
        if ({dm_we, dm_addr, dm_wd} !== 49'h0) begin
            failures++; $display("FAIL rst_dm: got we=%b addr=%h wd=%h expected all 0", dm_we, dm_addr, dm_wd);
        end
        checks++;
        if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== 66'h0) begin
            failures++; $display("FAIL rst_rdata: got rv=%b%b rd0=%h rd1=%h expected all 0", m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
        end
        checks++;
        if (busy !== EXP_BUSY_RST) begin
            failures++; $display("FAIL rst_busy: got %b expected %b", busy, EXP_BUSY_RST);
        end
        idle_inputs();
    endtask

`ifdef DM_CLEAR_EN
    // First release: full sweep with m0 holding a read of address 17
    task automatic test_clear();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 5'd17;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            #1;
            checks++;
            if ({busy, dm_we, dm_addr, dm_wd, m0_gnt} !== {1'b1, 1'b1, 16'(i), 32'h0, 1'b0}) begin
                failures++;
                $display("FAIL clear_cycle%0d: got busy=%b we=%b addr=%h wd=%h gnt=%b expected 1 1 %h 0 0",
                         i, busy, dm_we, dm_addr, dm_wd, m0_gnt, 16'(i));
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if ({busy, m0_gnt, dm_addr} !== {1'b0, 1'b1, 16'd17}) begin
            failures++; $display("FAIL clear_first_gnt: got busy=%b gnt=%b addr=%h expected 0 1 0011", busy, m0_gnt, dm_addr);
        end
        @(posedge clk); #1;
        checks++;
        if ({m0_rvalid, m0_rdata} !== {1'b1, 32'h0}) begin
            failures++; $display("FAIL clear_read17: got rv=%b rd=%h expected 1 00000000", m0_rvalid, m0_rdata);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_mid_sweep();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if ({busy, dm_we, dm_addr} !== {1'b1, 1'b1, 16'd10}) begin
            failures++; $display("FAIL midsweep_idx10: got busy=%b we=%b addr=%h expected 1 1 000a", busy, dm_we, dm_addr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, dm_we, dm_addr} !== {1'b1, 1'b0, 16'd0}) begin
            failures++; $display("FAIL midsweep_rst: got busy=%b we=%b addr=%h expected 1 0 0000", busy, dm_we, dm_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            #1;
            checks++;
            if ({busy, dm_we, dm_addr} !== {1'b1, 1'b1, 16'(i)}) begin
                failures++; $display("FAIL midsweep_restart%0d: got busy=%b we=%b addr=%h expected 1 1 %h", i, busy, dm_we, dm_addr, 16'(i));
            end
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL midsweep_end: got busy=%b expected 0", busy);
        end
    endtask
`endif

    task automatic test_single();
        m1_we = 1'b1; m1_addr = 5'd9; m1_wd = 32'hFFFF_FFFF;   // idle port with junk inputs
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 5'd5; m0_wd = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            failures++; $display("FAIL single_wr_gnt: got %b expected 10", {m0_gnt, m1_gnt});
        end
        checks++;
        if ({dm_we, dm_addr, dm_wd} !== {1'b1, 16'd5, 32'hDEAD_BEEF}) begin
            failures++; $display("FAIL single_wr_dm: got we=%b addr=%h wd=%h expected 1 0005 deadbeef", dm_we, dm_addr, dm_wd);
        end
        @(posedge clk); #1;
        checks++;
        if (m0_rvalid !== 1'b0) begin
            failures++; $display("FAIL single_wr_norvalid: got %b expected 0", m0_rvalid);
        end
        @(negedge clk);
        m0_we = 1'b0;
        #1;
        checks++;
        if ({m0_gnt, dm_we, dm_addr} !== {1'b1, 1'b0, 16'd5}) begin
            failures++; $display("FAIL single_rd_gnt: got gnt=%b we=%b addr=%h expected 1 0 0005", m0_gnt, dm_we, dm_addr);
        end
        @(posedge clk); #1;
        checks++;
        if ({m0_rvalid, m0_rdata, m1_rvalid} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
            failures++; $display("FAIL single_rd_data: got rv0=%b rd0=%h rv1=%b expected 1 deadbeef 0", m0_rvalid, m0_rdata, m1_rvalid);
        end
        @(negedge clk);
        m0_req = 1'b0;
        #1;
        checks++;
        if ({m0_gnt, m1_gnt, dm_we} !== 3'b000) begin
            failures++; $display("FAIL single_idle: got gnt=%b%b we=%b expected 000", m0_gnt, m1_gnt, dm_we);
        end
        @(posedge clk); #1;
        checks++;
        if ({m0_rvalid, m0_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
            failures++; $display("FAIL single_hold: got rv=%b rd=%h expected 0 deadbeef", m0_rvalid, m0_rdata);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_contention();
        do_reset();
        // Both write from reset: port 0 wins the first tie
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 5'd20; m0_wd = 32'h0BAD_F00D;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 5'd21; m1_wd = 32'hCAFE_0001;
        #1;
        checks++;
        if ({m0_gnt, m1_gnt, dm_wd} !== {2'b10, 32'h0BAD_F00D}) begin
            failures++; $display("FAIL tie_first: got gnt=%b%b wd=%h expected 10 0badf00d", m0_gnt, m1_gnt, dm_wd);
        end
        @(negedge clk);
        m0_req = 1'b0;
        #1;
        checks++;
        if ({m0_gnt, m1_gnt, dm_wd} !== {2'b01, 32'hCAFE_0001}) begin
            failures++; $display("FAIL tie_second: got gnt=%b%b wd=%h expected 01 cafe0001", m0_gnt, m1_gnt, dm_wd);
        end
        @(negedge clk);
        // Continuous read contention: grants alternate, starting with port 0
        m0_req = 1'b1; m0_we = 1'b0; m0_wd = 32'h0000_AAAA;
        m1_req = 1'b1; m1_we = 1'b0; m1_wd = 32'h0000_BBBB;
        for (int c = 0; c < 6; c++) begin
            bit p0;
            p0 = (c % 2 == 0);
            #1;
            checks++;
            if ({m0_gnt, m1_gnt} !== {p0, ~p0}) begin
                failures++; $display("FAIL cont_gnt%0d: got %b%b expected %b%b", c, m0_gnt, m1_gnt, p0, ~p0);
            end
            checks++;
            if ({dm_addr, dm_wd} !== (p0 ? {16'd20, 32'h0000_AAAA} : {16'd21, 32'h0000_BBBB})) begin
                failures++; $display("FAIL cont_mux%0d: got addr=%h wd=%h for port %0d", c, dm_addr, dm_wd, p0 ? 0 : 1);
            end
            @(posedge clk); #1;
            checks++;
            if ({m0_rvalid, m1_rvalid} !== {p0, ~p0}) begin
                failures++; $display("FAIL cont_rvalid%0d: got %b%b expected %b%b", c, m0_rvalid, m1_rvalid, p0, ~p0);
            end
            checks++;
            if ((p0 ? m0_rdata : m1_rdata) !== (p0 ? 32'h0BAD_F00D : 32'hCAFE_0001)) begin
                failures++; $display("FAIL cont_rdata%0d: got %h expected %h", c, p0 ? m0_rdata : m1_rdata, p0 ? 32'h0BAD_F00D : 32'hCAFE_0001);
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_hazard();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 5'd3; m1_wd = 32'h1234_5678;
        #1;
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b01) begin
            failures++; $display("FAIL hazard_wr_gnt: got %b%b expected 01", m0_gnt, m1_gnt);
        end
        @(posedge clk); #1;
        checks++;
        if (m1_rvalid !== 1'b0) begin
            failures++; $display("FAIL hazard_wr_norvalid: got %b expected 0", m1_rvalid);
        end
        @(negedge clk);
        m1_req = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 5'd3;
        #1;
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            failures++; $display("FAIL hazard_rd_gnt: got %b%b expected 10", m0_gnt, m1_gnt);
        end
        @(posedge clk); #1;
        checks++;
        if ({m0_rvalid, m0_rdata} !== {1'b1, 32'h1234_5678}) begin
            failures++; $display("FAIL hazard_rd_data: got rv=%b rd=%h expected 1 12345678", m0_rvalid, m0_rdata);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 5'd20;
        #1;
        checks++;
        if (m0_gnt !== 1'b1) begin
            failures++; $display("FAIL midread_gnt: got %b expected 1", m0_gnt);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        m0_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({m0_rvalid, m0_rdata} !== {1'b0, 32'h0}) begin
            failures++; $display("FAIL midread_cancel: got rv=%b rd=%h expected 0 00000000", m0_rvalid, m0_rdata);
        end
        @(posedge clk); #1;
        checks++;
        if (m0_rvalid !== 1'b0) begin
            failures++; $display("FAIL midread_stay: got rv=%b expected 0", m0_rvalid);
        end
        @(negedge clk);
        idle_inputs();
        do_reset();
    endtask

    initial begin
        idle_inputs();
        test_reset();
`ifdef DM_CLEAR_EN
        test_clear();
`else
        rst = 1'b0;
`endif
        test_single();
        test_contention();
        test_hazard();
        test_reset_mid_read();
`ifdef DM_CLEAR_EN
        test_reset_mid_sweep();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Shares the single-port data memory (32 words × 32 bits, combinational read, write on clk rising edge) between two requesters: port 0, the core's load/store unit, and port 1, the debug/program loader. Arbitration is round-robin and single-cycle. Read data is returned registered, one cycle after grant. An optional post-reset sweep zero-fills the memory before any requester is served. Sits between the datapath/loader and the data memory instance.

## Interface
- ADDR_W, 5: word-address width; memory depth 2^ADDR_W
- DATA_W, 32: data width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- m0_req  in  1  port 0 access request, level
- m0_we  in  1  port 0 write (1) / read (0)
- m0_addr  in  ADDR_W  port 0 word address
- m0_wd  in  DATA_W  port 0 write data
- m0_gnt  out  1  port 0 granted this cycle (combinational)
- m0_rdata  out  DATA_W  port 0 read data, registered
- m0_rvalid  out  1  port 0 read data valid, one-cycle pulse
- m1_req, m1_we, m1_addr, m1_wd, m1_gnt, m1_rdata, m1_rvalid: same as port 0, for port 1
- dm_addr  out  16  memory address, {zeros, selected addr}
- dm_we  out  1  memory write enable
- dm_wd  out  DATA_W  memory write data
- dm_rd  in  DATA_W  memory read data, combinational from dm_addr
- busy  out  1  clear sweep in progress

## Operation
- FSM states: CLEAR and SERVE. Reset enters CLEAR when DM_CLEAR_EN is defined, otherwise SERVE.
- CLEAR:
  - A counter clr_idx starts at 0. Each cycle drives dm_we=1, dm_wd=0, dm_addr=clr_idx, then increments.
  - After the write at index 2^ADDR_W−1, the FSM goes to SERVE.
  - busy=1. Both gnt=0. Requests are ignored and are not queued; requesters hold req.
- SERVE:
  - One req only: grant that port.
  - Both req: grant the port not granted most recently (last_gnt). last_gnt updates on every grant.
  - No req: no grant, dm_we=0.
  - dm_addr, dm_we and dm_wd mux combinationally from the granted port. A write commits at the same rising edge.
  - Granted read: at the rising edge, dm_rd is captured into mX_rdata and mX_rvalid is set for exactly one cycle.
  - A granted write produces no rvalid.
- A requester may keep req high for back-to-back accesses. Each gnt cycle is one completed access.
- mX_rdata holds its last value until the next read completes on that port.
- Ungranted port: dm_* unaffected by its inputs.

## Timing
- Reset values while rst is asserted:
  - m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, dm_we = 0
  - m0_rdata, m1_rdata, dm_wd, dm_addr = 0
  - last_gnt = 1 (port 0 wins the first tie)
  - clr_idx = 0
  - busy = 1 when DM_CLEAR_EN is defined, else 0
- rst asserted mid-sweep: the sweep restarts from index 0 after release.
- rst asserted mid-read: any pending rvalid is cancelled.
- Grant latency is 0 cycles: gnt is in the same cycle as req.
- Read latency is 1 cycle: rvalid is in the cycle after gnt.
- Throughput is one access per cycle in total. Under continuous contention each port gets every other cycle.
- With DM_CLEAR_EN, the sweep lasts 2^ADDR_W cycles after rst deassertion (32 at default). busy falls on the cycle the first grant becomes possible.
- Read of an address written in the immediately preceding cycle returns the new data.

## Configuration
- DM_CLEAR_EN defined:
  - CLEAR state, clr_idx counter and busy sweep are present.
  - Memory reads 0 everywhere after reset.
- DM_CLEAR_EN not defined:
  - No CLEAR state. FSM resets directly into SERVE and busy is tied to 0.
  - Memory contents after reset are whatever the memory holds; grants are possible in the first cycle after rst release.

## Test plan
- Reset with DM_CLEAR_EN: busy=1 for 32 cycles; dm_we=1 with addresses 0..31 and dm_wd=0 in order; m0_req held high gets m0_gnt only in cycle 33. A later read of address 17 returns 0.
- Single port: m0 writes 0xDEADBEEF to address 5, then reads address 5 → m0_gnt each cycle; m0_rvalid=1 one cycle after the read grant with m0_rdata=0xDEADBEEF.
- Contention: m0 and m1 both request continuously from reset → grants go m0, m1, m0, m1…; each rvalid appears on the correct port with that port's data.
- Write-then-read hazard: m1 writes 0x12345678 to address 3 in cycle N, m0 reads address 3 in cycle N+1 → m0_rdata=0x12345678 in cycle N+2.
- Reset mid-sweep: assert rst at clr_idx=10 → after release the sweep restarts at address 0 and busy lasts the full 32 cycles.
- Reset mid-read: assert rst the cycle after a read grant → m0_rvalid stays 0 and m0_rdata=0.
